// File: rtl/wide_add_sequencer.sv
// Wide (32*NUM_WORDS-bit) add/subtract sequencer built around one shared
// 32-bit carry-lookahead adder, processing operands LSW-first.

module cla_adder_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  // Eight 4-bit lookahead groups; group carries chain between groups.
  function automatic logic [32:0] cla32(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        cin);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    int unsigned base;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int unsigned k = 0; k < 8; k++) begin
      base = 4 * k;
      c[base+1] = g[base] | (p[base] & c[base]);
      c[base+2] = g[base+1] | (p[base+1] & g[base])
                | (p[base+1] & p[base] & c[base]);
      c[base+3] = g[base+2] | (p[base+2] & g[base+1])
                | (p[base+2] & p[base+1] & g[base])
                | (p[base+2] & p[base+1] & p[base] & c[base]);
      c[base+4] = g[base+3] | (p[base+3] & g[base+2])
                | (p[base+3] & p[base+2] & g[base+1])
                | (p[base+3] & p[base+2] & p[base+1] & g[base])
                | (p[base+3] & p[base+2] & p[base+1] & p[base] & c[base]);
    end
    return {c[32], p ^ c[31:0]};
  endfunction

  // Pure combinational add.
  always_comb begin
    {cout_o, sum_o} = cla32(a_i, b_i, cin_i);
  end

endmodule

module wide_add_sequencer #(
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [32*NUM_WORDS-1:0]   a_i,
  input  logic [32*NUM_WORDS-1:0]   b_i,
  input  logic                      cin_i,
  input  logic                      sub_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [32*NUM_WORDS-1:0]   sum_o,
  output logic                      cout_o,
  output logic                      ovf_o
);

  localparam int unsigned W    = 32 * NUM_WORDS;
  localparam int unsigned IDXW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [IDXW+4:0] base;
  logic [31:0]     a_word;
  logic [31:0]     b_word;
  logic [31:0]     add_sum;
  logic            add_cout;

  assign base   = {idx_q, 5'b0};
  assign a_word = a_q[base +: 32];
  assign b_word = b_q[base +: 32];

  cla_adder_32bit u_adder (
    .a_i    (a_word),
    .b_i    (b_word),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o = rsp_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

  // Next-state and datapath update: accept, step one word per cycle, hold result.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          a_d     = a_i;
          // Subtract as A + ~B + 1; cin_i is not used in that case.
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : cin_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: 32] = add_sum;
        carry_d           = add_cout;
        if (idx_q == LAST) begin
          cout_d      = add_cout;
          ovf_d       = (a_word[31] == b_word[31]) && (add_sum[31] != a_word[31]);
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (NUM_WORDS=4, 128-bit operands).

module tb_wide_add_sequencer;

  localparam int unsigned NW = 4;
  localparam int unsigned W  = 32 * NW;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  wide_add_sequencer #(.NUM_WORDS(NW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .cin_i       (cin),
    .sub_i       (sub),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain wide integer arithmetic, signed range check for overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W:0]          full;
    logic signed [W+1:0] sa;
    logic signed [W+1:0] sb;
    logic signed [W+1:0] sr;
    sa = $signed({{2{a[W-1]}}, a});
    sb = $signed({{2{b[W-1]}}, b});
    if (s) begin
      es = a - b;
      ec = (a >= b);
      sr = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      es   = full[W-1:0];
      ec   = full[W];
      sr   = sa + sb + {{(W+1){1'b0}}, c};
    end
    eo = !((sr[W+1:W-1] == 3'b000) || (sr[W+1:W-1] == 3'b111));
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) v[32*i +: 32] = $urandom;
    case ($urandom_range(0, 5))
      0: v = '1;
      1: v = '0;
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait for it to be accepted; inputs are scrambled afterwards.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
    int n;
    a_in = a; b_in = b; cin = c; sub = s; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    a_in = rand_wide(); b_in = rand_wide(); cin = $urandom; sub = $urandom;
  endtask

  // Called #1 after the accepting edge: checks latency and results, optionally acknowledges.
  task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input bit ack, input string tag);
    logic [W-1:0] es;
    logic         ec, eo;
    int           n;
    model(a, b, c, s, es, ec, eo);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    vectors++;
    if (n !== NW) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges required %0d", tag, n, NW);
    end
    vectors++;
    if (sum !== es) begin
      miscompares++;
      $display("FAIL %s sum: got %h required %h", tag, sum, es);
    end
    vectors++;
    if (cout !== ec) begin
      miscompares++;
      $display("FAIL %s cout: got %b required %b", tag, cout, ec);
    end
    vectors++;
    if (ovf !== eo) begin
      miscompares++;
      $display("FAIL %s ovf: got %b required %b", tag, ovf, eo);
    end
    if (ack) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      vectors++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL %s release: rsp_valid=%b req_ready=%b required 0/1", tag, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input string tag);
    issue(a, b, c, s);
    collect(a, b, c, s, 1'b1, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: rsp_valid=%b req_ready=%b required 0/0", rsp_valid, req_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = {32'h0, {96{1'b1}}}; b = 1;
    run_op(a, b, 1'b0, 1'b0, "word_carry");
    a = '1; b = '0;
    run_op(a, b, 1'b1, 1'b0, "all_ones_cin");
    a = 5; b = 7;
    run_op(a, b, 1'b1, 1'b1, "sub_borrow");
    a = {1'b0, {(W-1){1'b1}}}; b = 1;
    run_op(a, b, 1'b0, 1'b0, "add_ovf");
    b = {1'b1, {(W-1){1'b0}}};
    run_op(a, b, 1'b0, 1'b1, "sub_ovf");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(rand_wide(), rand_wide(), 1'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1, b1, a2, b2, es;
    logic         c1, s1, c2, s2, ec, eo;
    a1 = rand_wide(); b1 = rand_wide(); c1 = $urandom; s1 = $urandom;
    a2 = rand_wide(); b2 = rand_wide(); c2 = $urandom; s2 = $urandom;
    model(a1, b1, c1, s1, es, ec, eo);
    issue(a1, b1, c1, s1);
    collect(a1, b1, c1, s1, 1'b0, "bp_first");
    a_in = a2; b_in = b2; cin = c2; sub = s2; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || sum !== es || cout !== ec || ovf !== eo) begin
        miscompares++;
        $display("FAIL bp_hold: cyc %0d rsp_valid=%b req_ready=%b sum=%h cout=%b ovf=%b required 1/0 %h %b %b",
                 i, rsp_valid, req_ready, sum, cout, ovf, es, ec, eo);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
    end
    tick();
    req_valid = 1'b0;
    collect(a2, b2, c2, s2, 1'b1, "bp_second");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_op(rand_wide(), rand_wide(), 1'($urandom), 1'($urandom), "b2b");
  endtask

  task automatic test_reset_mid_run();
    issue(rand_wide(), rand_wide(), 1'($urandom), 1'($urandom));
    tick();
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_ready_in_reset: req_ready=%b required 0", req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_idle: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_no_rsp: cyc %0d rsp_valid=%b required 0", i, rsp_valid);
      end
    end
    run_op({32'h0, {96{1'b1}}}, 128'd1, 1'b0, 1'b0, "after_reset");
    run_op(rand_wide(), rand_wide(), 1'($urandom), 1'($urandom), "after_reset_rand");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs (NUM_WORDS*32)-bit add/subtract using one shared instance of the 32-bit CLA adder (cla_adder_32bit).
- Sequences operands LSW-first through the adder, one word per cycle, with the inter-word carry held in a register.
- Valid/ready request and response handshakes; sits between an operand source and the result consumer in the wide-arithmetic path.

Parameters:
- NUM_WORDS, 4, number of 32-bit words per operand; legal range >= 1; operand width W = 32*NUM_WORDS.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- req_valid_i  input  1  request operands valid.
- req_ready_o  output  1  block can accept a request.
- a_i  input  W  operand A.
- b_i  input  W  operand B.
- cin_i  input  1  carry-in; ignored when sub_i=1.
- sub_i  input  1  0: A+B+cin_i; 1: A-B.
- rsp_valid_o  output  1  result valid.
- rsp_ready_i  input  1  consumer accepts result.
- sum_o  output  W  result.
- cout_o  output  1  carry-out of MSB word; for subtract, 1 = no borrow.
- ovf_o  output  1  two's-complement signed overflow.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset:
  - rst_i high at an edge: state <= IDLE; word index, carry register, sum_o, cout_o, ovf_o and rsp_valid_o <= 0.
  - req_ready_o = (state==IDLE) && !rst_i.
  - Reset mid-RUN or in DONE abandons the operation; no response is emitted.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i && req_ready_o: latch A into the operand register; latch B, or ~B when sub_i=1.
  - Carry register <= sub_i ? 1 : cin_i; word index <= 0; go to RUN.
  - Later changes on a_i/b_i/cin_i/sub_i are ignored until the next acceptance.
- RUN:
  - Each cycle, the adder receives word[idx] of the latched A and B' plus the carry register.
  - Registered on the edge: sum word[idx] <= adder sum; carry register <= adder cout.
  - At idx == NUM_WORDS-1: cout_o <= adder cout; ovf_o <= (A_msb == B'_msb) && (adder sum_msb != A_msb); go to DONE; otherwise idx++.
- DONE:
  - rsp_valid_o=1. sum_o, cout_o and ovf_o are held stable.
  - On rsp_ready_i: go to IDLE.
  - req_ready_o=0 in RUN and DONE; no overlap between operations.
- Latency: request accepted at edge k; rsp_valid_o is high after edge k+NUM_WORDS.
- Throughput: minimum NUM_WORDS+2 cycles per operation (the response handshake cycle plus one IDLE cycle).
- NUM_WORDS=1: RUN lasts a single cycle.
- sum_o contents are undefined outside DONE; bench checks them only while rsp_valid_o=1.
- Arithmetic is modulo 2^W; carry-out is reported only via cout_o.
- rsp_valid_o and sum_o/cout_o/ovf_o are registered outputs; no combinational path from req_valid_i to any output except through req_ready_o.

Test Plan:
- NUM_WORDS=4; A=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1, cin_i=0, sub_i=0 -> sum_o=0x00000001_00000000_00000000_00000000, cout_o=0, ovf_o=0; rsp_valid_o rises exactly 4 edges after acceptance.
- A=all-ones (128b), B=0, cin_i=1 -> sum_o=0, cout_o=1, ovf_o=0.
- sub_i=1, A=5, B=7, cin_i=1 (ignored) -> sum_o=0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, cout_o=0 (borrow), ovf_o=0.
- A=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1, add -> sum_o=0x80000000_00000000_00000000_00000000, ovf_o=1, cout_o=0. Same A with sub_i=1, B=0x80000000_0..0 -> ovf_o=1.
- Backpressure:
  - Hold rsp_ready_i=0 for 10 cycles in DONE while req_valid_i=1 with new operands.
  - Required: rsp_valid_o stays 1, outputs stable, req_ready_o=0, nothing accepted.
  - Then raise rsp_ready_i for 1 cycle: the new request is accepted on the following edge in IDLE.
- Assert rst_i for one cycle during RUN at idx=2 -> after that edge state is IDLE and rsp_valid_o=0; req_ready_o=1 once rst_i is low; no response appears. A fresh request then completes with correct results.
